ifu_fetch: RTL and testbench

Instruction fetch unit that drives the fetch side of the IF/ID stage boundary.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid interface, one transaction outstanding at a time.
- Presents each fetched instruction and its address to the IF/ID register.
- Handles pipeline hold (stall) and jump redirect (flush), including discarding stale in-flight responses.

---
 rtl/ifu_fetch.sv | 194 +++++++++++++++++++
 tb/tb_ifu_fetch.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time over a
// req/gnt/rvalid port and registers the fetched instruction towards IF/ID.
//
// Memory handshake: mem_req_o is a request that, once driven, is held with a
// stable mem_addr_o until the cycle mem_gnt_i is seen high with it; that
// cycle transfers the request. Exactly one response (mem_rvalid_i high for
// one cycle with mem_rdata_i) follows each grant, one or more cycles later.
// Only one request may be outstanding, so rvalid is only meaningful in WAIT.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_kill;          // outstanding/granted transfer is stale, drop its data
  logic        w_kill_nxt;
  logic        r_pend;          // request driven last cycle and not granted yet
  logic        w_pend_nxt;
  logic [31:0] r_req_addr;      // address of the request currently driven / in flight
  logic [31:0] w_req_addr_nxt;
  logic [31:0] r_skid_data;
  logic [31:0] w_skid_data_nxt;
  logic [31:0] r_skid_addr;
  logic [31:0] w_skid_addr_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic [31:0] r_inst_addr;
  logic [31:0] w_inst_addr_nxt;
  logic        r_inst_valid;
  logic        w_inst_valid_nxt;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_jump_tgt;

  // A fresh request waits out a hold; one already on the bus stays until granted.
  assign w_req      = (r_state == S_REQ) && (!hold_i || r_pend);
  // A pending request keeps its address even if a jump has moved the PC.
  assign w_addr     = r_pend ? r_req_addr : r_pc;
  assign w_jump_tgt = jump_addr_i & ~32'h0000_0003;

  assign mem_req_o    = w_req;
  assign mem_addr_o   = w_addr;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
  assign inst_valid_o = r_inst_valid;

  // Next-state, PC, kill, skid and IF/ID output computation.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_kill_nxt      = r_kill;
    w_pend_nxt      = r_pend;
    w_req_addr_nxt  = w_req ? w_addr : r_req_addr;
    w_skid_data_nxt = r_skid_data;
    w_skid_addr_nxt = r_skid_addr;
    // Frozen under hold, otherwise a bubble unless something loads below.
    if (hold_i) begin
      w_inst_nxt       = r_inst;
      w_inst_addr_nxt  = r_inst_addr;
      w_inst_valid_nxt = r_inst_valid;
    end else begin
      w_inst_nxt       = NOP_INST;
      w_inst_addr_nxt  = r_inst_addr;
      w_inst_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_req && mem_gnt_i) begin
          w_state_nxt = S_WAIT;
          w_pend_nxt  = 1'b0;
          // A killed grant belongs to the old stream; PC already holds the target.
          if (!r_kill) begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end else if (w_req) begin
          w_pend_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          if (r_kill) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else if (!hold_i) begin
            w_inst_nxt       = mem_rdata_i;
            w_inst_addr_nxt  = r_req_addr;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = S_REQ;
          end else begin
            w_skid_data_nxt = mem_rdata_i;
            w_skid_addr_nxt = r_req_addr;
            w_state_nxt     = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (!hold_i) begin
          w_inst_nxt       = r_skid_data;
          w_inst_addr_nxt  = r_skid_addr;
          w_inst_valid_nxt = 1'b1;
          w_state_nxt      = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Redirect wins over everything, including hold.
    if (jump_en_i) begin
      w_pc_nxt         = w_jump_tgt;
      w_inst_nxt       = NOP_INST;
      w_inst_valid_nxt = 1'b0;
      case (r_state)
        S_REQ: begin
          if (w_req) begin
            w_kill_nxt = 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_kill_nxt = 1'b1;
          end
        end
        S_FULL: begin
          w_state_nxt = S_REQ;
        end
        default: begin
          w_state_nxt = S_REQ;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_pend       <= 1'b0;
      r_req_addr   <= RESET_PC;
      r_skid_data  <= 32'h0;
      r_skid_addr  <= 32'h0;
      r_inst       <= NOP_INST;
      r_inst_addr  <= 32'h0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_kill       <= w_kill_nxt;
      r_pend       <= w_pend_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_addr  <= w_skid_addr_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_addr  <= w_inst_addr_nxt;
      r_inst_valid <= w_inst_valid_nxt;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch. Cycle Cn is the cycle after the n-th rising
// edge following reset release (C0 = IDLE). Inputs change at posedge+1, the
// memory model drives gnt/rvalid at posedge+2 and samples the handshake at
// posedge+8; outputs are checked at the falling edge.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        hold_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  // second instance for PC wrap from the top of the address space
  logic        w2_hold;
  logic        w2_jump;
  logic [31:0] w2_jump_addr;
  logic        w2_req;
  logic [31:0] w2_addr;
  logic        w2_gnt;
  logic        w2_rvalid;
  logic [31:0] w2_rdata;
  logic [31:0] w2_inst;
  logic [31:0] w2_inst_addr;
  logic        w2_inst_valid;

  int n_vec;
  int n_err;

  // memory model knobs and state
  int          gnt_delay;
  int          rv_delay;
  logic        ovr_en;
  logic [31:0] ovr_addr;
  logic [31:0] ovr_data;
  logic        pend;
  logic [31:0] pend_addr;
  int          gwait;
  int          rwait;

  ifu_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold_i       (hold_i),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0013)) u_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold_i       (w2_hold),
    .jump_en_i    (w2_jump),
    .jump_addr_i  (w2_jump_addr),
    .mem_req_o    (w2_req),
    .mem_addr_o   (w2_addr),
    .mem_gnt_i    (w2_gnt),
    .mem_rvalid_i (w2_rvalid),
    .mem_rdata_i  (w2_rdata),
    .inst_o       (w2_inst),
    .inst_addr_o  (w2_inst_addr),
    .inst_valid_o (w2_inst_valid)
  );

  assign w2_gnt = w2_req;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory model: grants after gnt_delay unanswered request cycles, answers
  // rv_delay cycles after the cycle following the grant, data = 0xA0 + addr
  initial begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    pend         = 1'b0;
    pend_addr    = 32'h0;
    gwait        = 0;
    rwait        = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        pend         = 1'b0;
        gwait        = 0;
        rwait        = 0;
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        if (pend) begin
          if (rwait >= rv_delay) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = (ovr_en && pend_addr == ovr_addr) ? ovr_data : 32'hA0 + pend_addr;
          end else begin
            rwait++;
          end
        end
        mem_gnt_i = mem_req_o && !pend && (gwait >= gnt_delay);
      end
      #6;
      if (rst_n) begin
        if (mem_rvalid_i) pend = 1'b0;
        if (mem_req_o && mem_gnt_i) begin
          pend      = 1'b1;
          pend_addr = mem_addr_o;
          rwait     = 0;
          gwait     = 0;
        end else if (mem_req_o) begin
          gwait++;
        end
      end
    end
  end

  // driver: reset with default knobs; returns at posedge+1 right after release
  task automatic do_reset();
    gnt_delay   = 0;
    rv_delay    = 0;
    ovr_en      = 1'b0;
    ovr_addr    = 32'h0;
    ovr_data    = 32'h0;
    hold_i      = 1'b0;
    jump_en_i   = 1'b0;
    jump_addr_i = 32'h0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (inst_o !== NOP) begin n_err++; $display("FAIL rst_inst got %h want %h", inst_o, NOP); end
    n_vec++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_inst_addr got %h want 0", inst_addr_o); end
    n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", inst_valid_o); end
    n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", mem_req_o); end
    n_vec++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got %h want 0", mem_addr_o); end
  endtask

  task automatic test_zero_wait();
    logic exp_req;
    logic exp_v;
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      exp_req = (c % 2 == 1);
      exp_v   = (c >= 3) && (c % 2 == 1);
      n_vec++; if (mem_req_o !== exp_req) begin n_err++; $display("FAIL zw_req c%0d got %b want %b", c, mem_req_o, exp_req); end
      if (exp_req) begin
        n_vec++; if (mem_addr_o !== 32'((c - 1) * 2)) begin n_err++; $display("FAIL zw_addr c%0d got %h want %h", c, mem_addr_o, 32'((c - 1) * 2)); end
      end
      n_vec++; if (inst_valid_o !== exp_v) begin n_err++; $display("FAIL zw_valid c%0d got %b want %b", c, inst_valid_o, exp_v); end
      if (exp_v) begin
        n_vec++; if (inst_o !== 32'(32'hA0 + (c - 3) * 2)) begin n_err++; $display("FAIL zw_inst c%0d got %h want %h", c, inst_o, 32'(32'hA0 + (c - 3) * 2)); end
        n_vec++; if (inst_addr_o !== 32'((c - 3) * 2)) begin n_err++; $display("FAIL zw_inst_addr c%0d got %h want %h", c, inst_addr_o, 32'((c - 3) * 2)); end
      end else begin
        n_vec++; if (inst_o !== NOP) begin n_err++; $display("FAIL zw_nop c%0d got %h want %h", c, inst_o, NOP); end
      end
    end
  endtask

  task automatic test_gnt_delay();
    do_reset();
    repeat (3) @(negedge clk);
    gnt_delay = 3;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      n_vec++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL gd_req c%0d got %b want 1", c, mem_req_o); end
      n_vec++; if (mem_addr_o !== 32'h4) begin n_err++; $display("FAIL gd_addr c%0d got %h want 4", c, mem_addr_o); end
      if (c == 4 || c == 5) begin
        n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL gd_valid c%0d got %b want 0", c, inst_valid_o); end
      end
    end
    @(negedge clk);
    n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL gd_wait_req got %b want 0", mem_req_o); end
    @(negedge clk);
    n_vec++; if (mem_addr_o !== 32'h8) begin n_err++; $display("FAIL gd_next_addr got %h want 8", mem_addr_o); end
    n_vec++; if (inst_o !== 32'hA4) begin n_err++; $display("FAIL gd_inst got %h want a4", inst_o); end
    n_vec++; if (inst_addr_o !== 32'h4) begin n_err++; $display("FAIL gd_inst_addr got %h want 4", inst_addr_o); end
    n_vec++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL gd_inst_valid got %b want 1", inst_valid_o); end
  endtask

  task automatic test_hold();
    do_reset();
    ovr_en   = 1'b1;
    ovr_addr = 32'h8;
    ovr_data = 32'hDEAD_BEEF;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    hold_i = 1'b1;
    for (int c = 6; c <= 10; c++) begin
      @(negedge clk);
      n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL hold_req c%0d got %b want 0", c, mem_req_o); end
      n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL hold_valid c%0d got %b want 0", c, inst_valid_o); end
      n_vec++; if (inst_o !== NOP) begin n_err++; $display("FAIL hold_inst c%0d got %h want %h", c, inst_o, NOP); end
    end
    @(posedge clk); #1;
    hold_i = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL hold_full_req got %b want 0", mem_req_o); end
    n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL hold_full_valid got %b want 0", inst_valid_o); end
    @(negedge clk);
    n_vec++; if (inst_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL hold_skid_inst got %h want deadbeef", inst_o); end
    n_vec++; if (inst_addr_o !== 32'h8) begin n_err++; $display("FAIL hold_skid_addr got %h want 8", inst_addr_o); end
    n_vec++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_skid_valid got %b want 1", inst_valid_o); end
    n_vec++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL hold_next_req got %b want 1", mem_req_o); end
    n_vec++; if (mem_addr_o !== 32'hC) begin n_err++; $display("FAIL hold_next_addr got %h want c", mem_addr_o); end
  endtask

  task automatic test_jump_wait();
    do_reset();
    rv_delay = 2;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_0103;
    @(posedge clk); #1;
    jump_en_i = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      @(negedge clk);
      n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL jw_valid c%0d got %b want 0", c, inst_valid_o); end
      n_vec++; if (inst_o !== NOP) begin n_err++; $display("FAIL jw_inst c%0d got %h want %h", c, inst_o, NOP); end
      n_vec++; if (mem_req_o !== (c == 5)) begin n_err++; $display("FAIL jw_req c%0d got %b want %b", c, mem_req_o, (c == 5)); end
      if (c == 5) begin
        n_vec++; if (mem_addr_o !== 32'h100) begin n_err++; $display("FAIL jw_addr got %h want 100", mem_addr_o); end
      end
    end
    @(negedge clk);
    n_vec++; if (inst_o !== 32'h1A0) begin n_err++; $display("FAIL jw_first_inst got %h want 1a0", inst_o); end
    n_vec++; if (inst_addr_o !== 32'h100) begin n_err++; $display("FAIL jw_first_addr got %h want 100", inst_addr_o); end
    n_vec++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL jw_first_valid got %b want 1", inst_valid_o); end
  endtask

  task automatic test_jump_gnt();
    do_reset();
    @(negedge clk);
    @(posedge clk); #1;
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_0300;
    @(posedge clk); #1;
    jump_en_i = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL jg_valid c%0d got %b want 0", c, inst_valid_o); end
      if (c == 3) begin
        n_vec++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL jg_req got %b want 1", mem_req_o); end
        n_vec++; if (mem_addr_o !== 32'h300) begin n_err++; $display("FAIL jg_addr got %h want 300", mem_addr_o); end
      end
    end
    @(negedge clk);
    n_vec++; if (inst_o !== 32'h3A0) begin n_err++; $display("FAIL jg_inst got %h want 3a0", inst_o); end
    n_vec++; if (inst_addr_o !== 32'h300) begin n_err++; $display("FAIL jg_inst_addr got %h want 300", inst_addr_o); end
  endtask

  task automatic test_jump_rvalid_hold();
    do_reset();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_0200;
    hold_i      = 1'b1;
    @(posedge clk); #1;
    jump_en_i = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      @(negedge clk);
      n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL jrh_req c%0d got %b want 0", c, mem_req_o); end
      n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL jrh_valid c%0d got %b want 0", c, inst_valid_o); end
      n_vec++; if (inst_o !== NOP) begin n_err++; $display("FAIL jrh_inst c%0d got %h want %h", c, inst_o, NOP); end
    end
    @(posedge clk); #1;
    hold_i = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL jrh_new_req got %b want 1", mem_req_o); end
    n_vec++; if (mem_addr_o !== 32'h200) begin n_err++; $display("FAIL jrh_new_addr got %h want 200", mem_addr_o); end
    n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL jrh_no_skid5 got %b want 0", inst_valid_o); end
    @(negedge clk);
    n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL jrh_no_skid6 got %b want 0", inst_valid_o); end
    @(negedge clk);
    n_vec++; if (inst_o !== 32'h2A0) begin n_err++; $display("FAIL jrh_inst got %h want 2a0", inst_o); end
    n_vec++; if (inst_addr_o !== 32'h200) begin n_err++; $display("FAIL jrh_inst_addr got %h want 200", inst_addr_o); end
    n_vec++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL jrh_inst_valid got %b want 1", inst_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (7) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (inst_o !== NOP) begin n_err++; $display("FAIL rm_inst got %h want %h", inst_o, NOP); end
    n_vec++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL rm_inst_addr got %h want 0", inst_addr_o); end
    n_vec++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b want 0", inst_valid_o); end
    n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rm_req got %b want 0", mem_req_o); end
    n_vec++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rm_mem_addr got %h want 0", mem_addr_o); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (mem_addr_o !== 32'h0 || mem_req_o !== 1'b1) begin n_err++; $display("FAIL rm_restart got req %b addr %h want 1 0", mem_req_o, mem_addr_o); end
    repeat (2) @(negedge clk);
    n_vec++; if (inst_o !== 32'hA0 || inst_valid_o !== 1'b1) begin n_err++; $display("FAIL rm_first got %h/%b want a0/1", inst_o, inst_valid_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    n_vec++; if (w2_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_reset_addr got %h want fffffffc", w2_addr); end
    @(negedge clk);
    n_vec++; if (w2_req !== 1'b1 || w2_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first got req %b addr %h want 1 fffffffc", w2_req, w2_addr); end
    @(posedge clk); #1;
    w2_rvalid = 1'b1;
    w2_rdata  = 32'h5A5A_0001;
    @(posedge clk); #1;
    w2_rvalid = 1'b0;
    w2_rdata  = 32'h0;
    @(negedge clk);
    n_vec++; if (w2_req !== 1'b1 || w2_addr !== 32'h0) begin n_err++; $display("FAIL wrap_second got req %b addr %h want 1 0", w2_req, w2_addr); end
    n_vec++; if (w2_inst !== 32'h5A5A_0001) begin n_err++; $display("FAIL wrap_inst got %h want 5a5a0001", w2_inst); end
    n_vec++; if (w2_inst_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_inst_addr got %h want fffffffc", w2_inst_addr); end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    gnt_delay    = 0;
    rv_delay     = 0;
    ovr_en       = 1'b0;
    ovr_addr     = 32'h0;
    ovr_data     = 32'h0;
    hold_i       = 1'b0;
    jump_en_i    = 1'b0;
    jump_addr_i  = 32'h0;
    w2_hold      = 1'b0;
    w2_jump      = 1'b0;
    w2_jump_addr = 32'h0;
    w2_rvalid    = 1'b0;
    w2_rdata     = 32'h0;
    rst_n        = 1'b0;
    test_reset();
    test_zero_wait();
    test_gnt_delay();
    test_hold();
    test_jump_wait();
    test_jump_gnt();
    test_jump_rvalid_hold();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
